pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC formation for the MIPS datapath.
- Selects among sequential fetch, branch target, J/JAL pseudo-direct target ({PC+4[31:28], instr_index, 2'b00}) and JR register target.
- Registers the JAL link value and generates a one-cycle flush after every taken redirect.
- Sits between the decode/control unit and the instruction memory address port.

Parameters:
- NBits, 32, datapath and PC width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, redirect target on a misaligned JR (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC, state and link outputs.
- branch_taken  input  1  conditional branch resolved taken this cycle.
- branch_offset  input  16  raw immediate of the branch.
- jump  input  1  J or JAL decoded.
- jal  input  1  JAL decoded; only meaningful with jump=1.
- instr_index  input  26  jump target field.
- jr  input  1  JR decoded.
- jr_target  input  NBits  rs register value.
- pc  output  NBits  current fetch address.
- fetch_valid  output  1  instruction at pc is to be executed.
- flush  output  1  kill the instruction currently fetched.
- link_valid  output  1  one-cycle write strobe for $ra.
- link_data  output  NBits  return address (PC+8 is not used; PC+4 of the JAL).
- addr_err  output  1  misaligned JR pulse (optional feature).

Behaviour:
- The rising edge of clk is the only clock. reset is synchronous, active-high, sampled on that edge.
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - fetch_valid=0, flush=0, link_valid=0, link_data=0, addr_err=0.
- Arithmetic:
  - pc_plus4 = pc+4, modulo 2^NBits (0xFFFF_FFFC wraps to 0).
  - Branch target = pc_plus4 + (sign-extended branch_offset << 2), modulo 2^NBits.
  - Jump target = {pc_plus4[31:28], instr_index, 2'b00}.
- Next-PC priority when state=RUN and stall=0: jr > jump > branch_taken > pc_plus4. Lower-priority simultaneous requests are ignored.
- Any of jr, jump or branch_taken accepted means a taken redirect.
- FSM:
  - BOOT: fetch_valid=0. Always goes to RUN on the next cycle; pc is held. This gives one bubble after reset.
  - RUN: fetch_valid=1.
    - stall=1: hold everything.
    - Taken redirect: pc takes the selected target and the FSM goes to REDIRECT.
    - Otherwise: pc takes pc_plus4.
  - REDIRECT: flush=1 and fetch_valid=0 for exactly one cycle.
    - pc takes pc_plus4.
    - Requests are ignored, because they come from a flushed slot.
    - Goes to RUN.
    - stall=1 in REDIRECT holds the state, and flush stays high.
- Link:
  - A JAL accepted in RUN registers link_data=pc_plus4 and asserts link_valid for one cycle, in the next cycle.
  - link_valid is cleared in the cycle after that, even if stall=1.
- reset mid-operation overrides every input, including a pending redirect, REDIRECT state and stall.
- Inputs are ignored in BOOT and REDIRECT.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - An accepted JR with jr_target[1:0]!=0 redirects to EXC_VECTOR instead of jr_target.
  - addr_err pulses for one cycle, aligned with the REDIRECT cycle.
  - The link logic is unaffected.
- Undefined:
  - jr_target[1:0] is forced to 2'b00.
  - addr_err is tied to 0.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum {BOOT, RUN, REDIRECT};
  - constants RESET_PC_DEF and EXC_VECTOR_DEF;
  - a next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
- One sub-module, pc_target_mux: combinational target formation and priority select.
- The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset, then free-run for 4 cycles:
  - pc=0x0040_0000, fetch_valid=0 during BOOT;
  - then pc=0x0040_0004, 0x0040_0008 with fetch_valid=1.
- J with instr_index=0x0100010 at pc=0x0040_0008:
  - next pc=0x0040_0040;
  - flush=1 for one cycle;
  - then pc=0x0040_0044.
- JAL at pc=0x0040_0010:
  - link_valid=1 and link_data=0x0040_0014 in the next cycle only.
- Branch with offset 0xFFFF at pc=0x0040_0020, with jr=1 and jr_target=0x0040_1000 in the same cycle:
  - JR wins, pc=0x0040_1000.
  - Branch alone instead gives pc=0x0040_0020.
- stall held 3 cycles in RUN and then in REDIRECT:
  - pc is constant;
  - flush stays high during the REDIRECT stall;
  - reset asserted mid-stall returns pc to 0x0040_0000 and state to BOOT.
- With PC_ALIGN_CHECK_EN, JR to 0x0040_1002:
  - pc=0x8000_0180, addr_err pulse.
  - Without the macro, the same JR gives pc=0x0040_1000.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// Holds the FSM state encoding and the next-PC source select encoding.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC formation: sequential, branch, pseudo-direct jump and JR targets,
// priority jr > jump > branch > sequential. PC_ALIGN_CHECK_EN enables misaligned-JR trapping.
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter int               NBits      = 32,
    parameter logic [NBits-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [NBits-1:0] pc_i,
    input  logic             branch_taken_i,
    input  logic [15:0]      branch_offset_i,
    input  logic             jump_i,
    input  logic [25:0]      instr_index_i,
    input  logic             jr_i,
    input  logic [NBits-1:0] jr_target_i,
    output logic [NBits-1:0] next_pc_o,
    output logic [NBits-1:0] pc_plus4_o,
    output sel_e             sel_o,
    output logic             misalign_o
);

    logic [NBits-1:0] pc_plus4_d;
    logic [NBits-1:0] br_target_d;
    logic [NBits-1:0] j_target_d;
    logic [NBits-1:0] jr_pc_d;
    logic             misalign_d;

    assign pc_plus4_d  = pc_i + NBits'(4);
    assign br_target_d = pc_plus4_d + {{(NBits-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign j_target_d  = {pc_plus4_d[NBits-1:28], instr_index_i, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_d = (jr_target_i[1:0] != 2'b00);
`else
    assign misalign_d = 1'b0;
`endif

    // Without the check the low bits are simply dropped, so misalign_d is constant 0.
    assign jr_pc_d = misalign_d ? EXC_VECTOR : (jr_target_i & ~NBits'(3));

    always_comb begin
        sel_o = SEL_SEQ;
        if (jr_i)
            sel_o = SEL_JR;
        else if (jump_i)
            sel_o = SEL_J;
        else if (branch_taken_i)
            sel_o = SEL_BR;
    end

    always_comb begin
        next_pc_o = pc_plus4_d;
        case (sel_o)
            SEL_BR:  next_pc_o = br_target_d;
            SEL_J:   next_pc_o = j_target_d;
            SEL_JR:  next_pc_o = jr_pc_d;
            default: next_pc_o = pc_plus4_d;
        endcase
    end

    assign pc_plus4_o = pc_plus4_d;
    assign misalign_o = jr_i && misalign_d;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: BOOT bubble, RUN fetch, one-cycle REDIRECT flush, JAL link.
// Optional PC_ALIGN_CHECK_EN macro traps misaligned JR to EXC_VECTOR and pulses addr_err.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               NBits      = 32,
    parameter logic [NBits-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [NBits-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic             jal,
    input  logic [25:0]      instr_index,
    input  logic             jr,
    input  logic [NBits-1:0] jr_target,
    output logic [NBits-1:0] pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic             link_valid,
    output logic [NBits-1:0] link_data,
    output logic             addr_err
);

    state_e           state_q;
    logic [NBits-1:0] pc_q;
    logic             fetch_valid_q;
    logic             flush_q;
    logic             link_valid_q;
    logic [NBits-1:0] link_data_q;
    logic             addr_err_q;

    logic [NBits-1:0] next_pc_d;
    logic [NBits-1:0] pc_plus4_d;
    sel_e             sel_d;
    logic             misalign_d;

    pc_target_mux #(
        .NBits      (NBits),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target_mux (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .jump_i          (jump),
        .instr_index_i   (instr_index),
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .next_pc_o       (next_pc_d),
        .pc_plus4_o      (pc_plus4_d),
        .sel_o           (sel_d),
        .misalign_o      (misalign_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            link_valid_q  <= 1'b0;
            link_data_q   <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            // Link and error strobes are single-cycle regardless of stall.
            link_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                    flush_q       <= 1'b0;
                end
                RUN: begin
                    if (!stall) begin
                        pc_q <= next_pc_d;
                        if (sel_d != SEL_SEQ) begin
                            state_q       <= REDIRECT;
                            fetch_valid_q <= 1'b0;
                            flush_q       <= 1'b1;
                            addr_err_q    <= misalign_d;
                        end
                        if (sel_d == SEL_J && jal) begin
                            link_valid_q <= 1'b1;
                            link_data_q  <= pc_plus4_d;
                        end
                    end
                end
                REDIRECT: begin
                    if (!stall) begin
                        pc_q          <= pc_plus4_d;
                        state_q       <= RUN;
                        fetch_valid_q <= 1'b1;
                        flush_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= BOOT;
                    fetch_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign link_valid  = link_valid_q;
    assign link_data   = link_data_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; honours PC_ALIGN_CHECK_EN for the JR alignment case.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        jump = 1'b0;
    logic        jal = 1'b0;
    logic [25:0] instr_index = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        link_valid;
    logic [31:0] link_data;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jal           (jal),
        .instr_index   (instr_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; branch_offset = 0; jump = 0; jal = 0;
        instr_index = 0; jr = 0; jr_target = 0;
    endtask

    // Leaves DUT in BOOT with pc=RESET_PC; n further ticks reach pc = 0x0040_0000 + 4*(n-1).
    task automatic do_reset_and_run(input int n);
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset_and_run(0);
        total++; if (pc !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0040_0000); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (link_valid !== 1'b0 || link_data !== 32'h0) begin bad++; $display("FAIL reset_link got=%b/%h exp=0/0", link_valid, link_data); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        tick();
        total++; if (pc !== 32'h0040_0000 || fetch_valid !== 1'b1) begin bad++; $display("FAIL boot_exit got=%h/%b exp=00400000/1", pc, fetch_valid); end
        tick();
        total++; if (pc !== 32'h0040_0004 || fetch_valid !== 1'b1) begin bad++; $display("FAIL seq1 got=%h/%b exp=00400004/1", pc, fetch_valid); end
        tick();
        total++; if (pc !== 32'h0040_0008 || fetch_valid !== 1'b1) begin bad++; $display("FAIL seq2 got=%h/%b exp=00400008/1", pc, fetch_valid); end
    endtask

    task automatic test_jump();
        do_reset_and_run(3);
        jump = 1; instr_index = 26'h0100010;
        tick();
        jump = 0; instr_index = 0;
        total++; if (pc !== 32'h0040_0040) begin bad++; $display("FAIL j_target got=%h exp=00400040", pc); end
        total++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL j_flush got=%b/%b exp=1/0", flush, fetch_valid); end
        total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL j_no_link got=%b exp=0", link_valid); end
        tick();
        total++; if (pc !== 32'h0040_0044 || flush !== 1'b0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL j_after got=%h/%b/%b exp=00400044/0/1", pc, flush, fetch_valid); end
    endtask

    task automatic test_jal();
        do_reset_and_run(5);
        total++; if (pc !== 32'h0040_0010) begin bad++; $display("FAIL jal_setup got=%h exp=00400010", pc); end
        jump = 1; jal = 1; instr_index = 26'h0100100;
        tick();
        jump = 0; jal = 0; instr_index = 0; stall = 1;
        total++; if (link_valid !== 1'b1 || link_data !== 32'h0040_0014) begin bad++; $display("FAIL jal_link got=%b/%h exp=1/00400014", link_valid, link_data); end
        total++; if (pc !== 32'h0040_0400) begin bad++; $display("FAIL jal_target got=%h exp=00400400", pc); end
        tick();
        total++; if (link_valid !== 1'b0 || link_data !== 32'h0040_0014) begin bad++; $display("FAIL jal_link_clear got=%b/%h exp=0/00400014", link_valid, link_data); end
        total++; if (pc !== 32'h0040_0400 || flush !== 1'b1) begin bad++; $display("FAIL jal_redirect_stall got=%h/%b exp=00400400/1", pc, flush); end
        stall = 0;
        tick();
        total++; if (pc !== 32'h0040_0404 || flush !== 1'b0) begin bad++; $display("FAIL jal_after got=%h/%b exp=00400404/0", pc, flush); end
    endtask

    task automatic test_priority();
        do_reset_and_run(9);
        branch_taken = 1; branch_offset = 16'hFFFF; jr = 1; jr_target = 32'h0040_1000;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h0040_1000 || flush !== 1'b1) begin bad++; $display("FAIL prio_jr got=%h/%b exp=00401000/1", pc, flush); end
        tick();
        total++; if (pc !== 32'h0040_1004) begin bad++; $display("FAIL prio_jr_after got=%h exp=00401004", pc); end
        do_reset_and_run(9);
        branch_taken = 1; branch_offset = 16'hFFFF;
        tick();
        total++; if (pc !== 32'h0040_0020 || flush !== 1'b1) begin bad++; $display("FAIL branch_back got=%h/%b exp=00400020/1", pc, flush); end
        // Request held into the flushed slot must be ignored.
        tick();
        branch_taken = 0; branch_offset = 0;
        total++; if (pc !== 32'h0040_0024 || flush !== 1'b0) begin bad++; $display("FAIL redirect_ignore got=%h/%b exp=00400024/0", pc, flush); end
        branch_taken = 1; branch_offset = 16'h0004;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h0040_0038) begin bad++; $display("FAIL branch_fwd got=%h exp=00400038", pc); end
        tick();
        jump = 1; jr = 0; branch_taken = 1; branch_offset = 16'h0010; instr_index = 26'h0000100;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h0000_0400) begin bad++; $display("FAIL prio_j_over_br got=%h exp=00000400", pc); end
    endtask

    task automatic test_stall();
        do_reset_and_run(2);
        stall = 1; jump = 1; instr_index = 26'h0100010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 32'h0040_0004 || fetch_valid !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL run_stall%0d got=%h/%b/%b exp=00400004/1/0", i, pc, fetch_valid, flush); end
        end
        stall = 0;
        tick();
        jump = 0; instr_index = 0; stall = 1;
        total++; if (pc !== 32'h0040_0040 || flush !== 1'b1) begin bad++; $display("FAIL stall_redirect got=%h/%b exp=00400040/1", pc, flush); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 32'h0040_0040 || flush !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL redir_stall%0d got=%h/%b/%b exp=00400040/1/0", i, pc, flush, fetch_valid); end
        end
        reset = 1;
        tick();
        reset = 0; stall = 0;
        total++; if (pc !== 32'h0040_0000 || flush !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL midstall_reset got=%h/%b/%b exp=00400000/0/0", pc, flush, fetch_valid); end
        tick();
        total++; if (pc !== 32'h0040_0000 || fetch_valid !== 1'b1) begin bad++; $display("FAIL midstall_boot got=%h/%b exp=00400000/1", pc, fetch_valid); end
    endtask

    task automatic test_wrap();
        do_reset_and_run(1);
        jr = 1; jr_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_jr got=%h exp=fffffffc", pc); end
        tick();
        total++; if (pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc); end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h8000_0180; exp_err = 1'b1;
`else
        exp_pc = 32'h0040_1000; exp_err = 1'b0;
`endif
        do_reset_and_run(1);
        jr = 1; jr_target = 32'h0040_1002;
        tick();
        clear_inputs();
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL align_pc got=%h exp=%h", pc, exp_pc); end
        total++; if (addr_err !== exp_err || flush !== 1'b1) begin bad++; $display("FAIL align_err got=%b/%b exp=%b/1", addr_err, flush, exp_err); end
        tick();
        total++; if (addr_err !== 1'b0 || pc !== exp_pc + 32'd4) begin bad++; $display("FAIL align_after got=%b/%h exp=0/%h", addr_err, pc, exp_pc + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_jal();
        test_priority();
        test_stall();
        test_wrap();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
